// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared constants for the I2C register sequencer: WISHBONE register
// offsets of the I2C master core, CR/SR bit values, phases, FSM states.
package i2c_reg_sequencer_pkg;

  localparam logic [2:0] ADR_PRERLO  = 3'd0;
  localparam logic [2:0] ADR_PRERHI  = 3'd1;
  localparam logic [2:0] ADR_CTR     = 3'd2;
  localparam logic [2:0] ADR_TXR_RXR = 3'd3;
  localparam logic [2:0] ADR_CR_SR   = 3'd4;

  localparam logic [7:0] CTR_EN  = 8'h80;
  localparam logic [7:0] CR_STA  = 8'h80;
  localparam logic [7:0] CR_STO  = 8'h40;
  localparam logic [7:0] CR_RD   = 8'h20;
  localparam logic [7:0] CR_WR   = 8'h10;
  localparam logic [7:0] CR_NACK = 8'h08;

  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  localparam logic [1:0] P1 = 2'd0;
  localparam logic [1:0] P2 = 2'd1;
  localparam logic [1:0] P3 = 2'd2;
  localparam logic [1:0] P4 = 2'd3;

  typedef enum logic [3:0] {
    S_INIT_PRL,
    S_INIT_PRH,
    S_INIT_CTR0,
    S_INIT_CTR,
    S_IDLE,
    S_TXR,
    S_CR,
    S_POLL,
    S_RXR,
    S_STOP,
    S_STOP_POLL,
    S_FINISH
  } state_e;

endpackage

// File: rtl/i2c_reg_sequencer_wbm.sv
// Single-access WISHBONE master: go_i starts one cycle, done_o pulses
// after ack/err with err_o and rdata_o; cyc/stb drop as soon as it ends.
module i2c_wbm_single (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       go_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i,
  input  logic       wbm_err_i
);

  logic       cyc_q;
  logic       we_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic       done_q;
  logic       err_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!cyc_q) begin
        if (go_i) begin
          cyc_q <= 1'b1;
          we_q  <= we_i;
          adr_q <= adr_i;
          dat_q <= dat_i;
        end
      end else if (wbm_ack_i || wbm_err_i) begin
        cyc_q   <= 1'b0;
        done_q  <= 1'b1;
        err_q   <= wbm_err_i;
        rdata_q <= wbm_dat_i;
      end
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Drives an OpenCores I2C master core: init prescale/enable, then one
// register write or read per req_i; reports done_o, rdata_o, status_o.
module i2c_reg_sequencer
  import i2c_reg_sequencer_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd199,
  parameter logic [19:0] TIMEOUT  = 20'hFFFFF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_i,
  input  logic       req_rd_i,
  input  logic [6:0] dev_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wdata_i,
  output logic       ready_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic [2:0] status_o,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i,
  input  logic       wbm_err_i
);

  state_e      state_q;
  logic [1:0]  phase_q;
  logic        rd_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic [2:0]  status_q;
  logic        ready_q;
  logic        done_q;
  logic        go_q;
  logic        pend_q;
  logic        reinit_q;
  logic [19:0] tmo_q;
  logic        acc_we_q;
  logic [2:0]  acc_adr_q;
  logic [7:0]  acc_dat_q;

  logic        acc_we_d;
  logic [2:0]  acc_adr_d;
  logic [7:0]  acc_dat_d;
  logic [7:0]  txr_val;
  logic [7:0]  cr_val;
  logic        stop_issued;
  logic        m_done;
  logic        m_err;
  logic [7:0]  m_rdata;

  i2c_wbm_single u_wbm (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .go_i      (go_q),
    .we_i      (acc_we_q),
    .adr_i     (acc_adr_q),
    .dat_i     (acc_dat_q),
    .done_o    (m_done),
    .err_o     (m_err),
    .rdata_o   (m_rdata),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i)
  );

  always_comb begin
    txr_val = {dev_q, 1'b0};
    cr_val  = CR_STA | CR_WR;
    unique case (phase_q)
      P1: ;
      P2: begin
        txr_val = reg_q;
        cr_val  = CR_WR;
      end
      P3: begin
        if (rd_q) begin
          txr_val = {dev_q, 1'b1};
        end else begin
          txr_val = wdata_q;
          cr_val  = CR_STO | CR_WR;
        end
      end
      P4: cr_val = CR_STO | CR_RD | CR_NACK;
      default: ;
    endcase
  end

  // Phases whose CR command already carried STO ignore RxACK
  assign stop_issued = (phase_q == P4) || (phase_q == P3 && !rd_q);

  always_comb begin
    acc_we_d  = 1'b1;
    acc_adr_d = ADR_CR_SR;
    acc_dat_d = '0;
    unique case (state_q)
      S_INIT_PRL: begin
        acc_adr_d = ADR_PRERLO;
        acc_dat_d = PRESCALE[7:0];
      end
      S_INIT_PRH: begin
        acc_adr_d = ADR_PRERHI;
        acc_dat_d = PRESCALE[15:8];
      end
      S_INIT_CTR0: acc_adr_d = ADR_CTR;
      S_INIT_CTR: begin
        acc_adr_d = ADR_CTR;
        acc_dat_d = CTR_EN;
      end
      S_TXR: begin
        acc_adr_d = ADR_TXR_RXR;
        acc_dat_d = txr_val;
      end
      S_CR:   acc_dat_d = cr_val;
      S_STOP: acc_dat_d = CR_STO;
      S_POLL, S_STOP_POLL: acc_we_d = 1'b0;
      S_RXR: begin
        acc_we_d  = 1'b0;
        acc_adr_d = ADR_TXR_RXR;
      end
      default: acc_we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_INIT_PRL;
      phase_q   <= P1;
      rd_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      go_q      <= 1'b0;
      pend_q    <= 1'b0;
      reinit_q  <= 1'b0;
      tmo_q     <= '0;
      acc_we_q  <= 1'b0;
      acc_adr_q <= '0;
      acc_dat_q <= '0;
    end else begin
      go_q   <= 1'b0;
      done_q <= 1'b0;
      if (state_q == S_POLL || state_q == S_STOP_POLL) begin
        tmo_q <= tmo_q + 20'd1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (req_i) begin
            rd_q     <= req_rd_i;
            dev_q    <= dev_addr_i;
            reg_q    <= reg_addr_i;
            wdata_q  <= wdata_i;
            status_q <= '0;
            phase_q  <= P1;
            ready_q  <= 1'b0;
            state_q  <= S_TXR;
          end
        end
        S_FINISH: begin
          state_q <= reinit_q ? S_INIT_CTR0 : S_IDLE;
          ready_q <= !reinit_q;
        end
        default: begin
          if (!pend_q) begin
            go_q      <= 1'b1;
            pend_q    <= 1'b1;
            acc_we_q  <= acc_we_d;
            acc_adr_q <= acc_adr_d;
            acc_dat_q <= acc_dat_d;
          end else if (m_done) begin
            pend_q <= 1'b0;
            if (m_err) begin
              status_q[2] <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= S_FINISH;
            end else begin
              unique case (state_q)
                S_INIT_PRL:  state_q <= S_INIT_PRH;
                S_INIT_PRH:  state_q <= S_INIT_CTR;
                S_INIT_CTR0: begin
                  reinit_q <= 1'b0;
                  state_q  <= S_INIT_CTR;
                end
                S_INIT_CTR: begin
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
                end
                S_TXR: state_q <= S_CR;
                S_CR: begin
                  tmo_q   <= '0;
                  state_q <= S_POLL;
                end
                S_POLL: begin
                  if (m_rdata[SR_TIP]) begin
                    if (tmo_q >= TIMEOUT) begin
                      status_q[2] <= 1'b1;
                      reinit_q    <= 1'b1;
                      done_q      <= 1'b1;
                      state_q     <= S_FINISH;
                    end
                  end else if (m_rdata[SR_AL]) begin
                    status_q[1] <= 1'b1;
                    done_q      <= 1'b1;
                    state_q     <= S_FINISH;
                  end else if (m_rdata[SR_RXACK] && !stop_issued) begin
                    status_q[0] <= 1'b1;
                    state_q     <= S_STOP;
                  end else if (phase_q == P3 && !rd_q) begin
                    status_q[0] <= m_rdata[SR_RXACK];
                    done_q      <= 1'b1;
                    state_q     <= S_FINISH;
                  end else if (phase_q == P4) begin
                    state_q <= S_RXR;
                  end else begin
                    // read P3 -> P4 has no TXR byte to load
                    phase_q <= phase_q + 2'd1;
                    state_q <= (phase_q == P3) ? S_CR : S_TXR;
                  end
                end
                S_RXR: begin
                  rdata_q <= m_rdata;
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
                end
                S_STOP: begin
                  tmo_q   <= '0;
                  state_q <= S_STOP_POLL;
                end
                S_STOP_POLL: begin
                  if (!m_rdata[SR_BUSY]) begin
                    done_q  <= 1'b1;
                    state_q <= S_FINISH;
                  end else if (tmo_q >= TIMEOUT) begin
                    status_q[2] <= 1'b1;
                    reinit_q    <= 1'b1;
                    done_q      <= 1'b1;
                    state_q     <= S_FINISH;
                  end
                end
                default: state_q <= S_INIT_PRL;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign rdata_o  = rdata_q;
  assign status_o = status_q;

endmodule
